stage_memory_access: RTL and testbench

Pipeline stage directly downstream of the execution stage. It performs loads and stores against an on-chip data memory, which is byte-addressed, little-endian and word-organised. It also holds the MEM/WB pipeline register and forwards write-back control to the write-back stage. A second read-only port lets the debug unit dump memory while the pipeline is halted.

---
 rtl/stage_memory_access_pkg.sv | 25 ++
 rtl/stage_memory_access_data_memory.sv | 38 +++
 rtl/stage_memory_access.sv | 122 ++++++++++++
 tb/tb_stage_memory_access.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/stage_memory_access_pkg.sv
// Definitions shared by the decode, execution and memory-access stages:
// load/store type codes, the data width and small type-classification helpers.
package stage_memory_access_pkg;

  localparam int DATA_W    = 32;
  localparam int NUM_LANES = DATA_W / 8;

  typedef enum logic [2:0] {
    LS_BYTE   = 3'b000,
    LS_HALF   = 3'b001,
    LS_WORD   = 3'b010,
    LS_BYTE_U = 3'b011,
    LS_HALF_U = 3'b100
  } ls_type_e;

  function automatic logic is_half_type(input logic [2:0] t);
    return (t == LS_HALF) || (t == LS_HALF_U);
  endfunction

  // Codes 101..111 are illegal and fall back to a full-word access.
  function automatic logic is_word_type(input logic [2:0] t);
    return (t == LS_WORD) || (t >= 3'd5);
  endfunction

endpackage

// File: rtl/stage_memory_access_data_memory.sv
// Word-organised data RAM: one byte-enable write/read port for the pipeline
// and one independent read-only port for the debug unit.
module data_memory
  import stage_memory_access_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [NUM_LANES-1:0] byte_en,
  input  logic [DATA_W-1:0]    wr_data,
  output logic [DATA_W-1:0]    rd_data,
  input  logic [ADDR_W-1:0]    dbg_addr,
  output logic [DATA_W-1:0]    dbg_data
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_LANES; i++) begin
      if (byte_en[i]) mem[addr][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  // Reads sample the array before this edge's write: read-old-data behaviour.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data  <= '0;
      dbg_data <= '0;
    end else begin
      if (rd_en) rd_data <= mem[addr];
      dbg_data <= mem[dbg_addr];
    end
  end

endmodule

// File: rtl/stage_memory_access.sv
// Memory-access pipeline stage: byte-lane loads/stores against the data RAM,
// misalignment detection and the MEM/WB pipeline register.
module stage_memory_access
  import stage_memory_access_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_enable,
  input  logic [31:0]       i_ALU_res,
  input  logic [31:0]       i_rt_reg,
  input  logic [31:0]       i_pc_to_reg,
  input  logic [4:0]        i_addr_reg_dst,
  input  logic              is_RegWrite,
  input  logic              is_MemtoReg,
  input  logic              is_MemWrite,
  input  logic              is_MemRead,
  input  logic              is_select_addr_reg,
  input  logic [2:0]        is_load_store_type,
  input  logic [ADDR_W-1:0] i_debug_addr,
  output logic [31:0]       o_mem_data,
  output logic [31:0]       o_ALU_res,
  output logic [31:0]       o_pc_to_reg,
  output logic [4:0]        o_addr_reg_dst,
  output logic              os_RegWrite,
  output logic              os_MemtoReg,
  output logic              os_select_addr_reg,
  output logic              os_misaligned,
  output logic [31:0]       o_debug_data
);

  logic [ADDR_W-1:0]    word_idx;
  logic [1:0]           lane;
  logic                 misaligned;
  logic [NUM_LANES-1:0] byte_en;
  logic [DATA_W-1:0]    wr_data;
  logic [DATA_W-1:0]    rd_word;
  logic [1:0]           lane_q;
  logic [2:0]           type_q;
  logic [7:0]           sel_byte;
  logic [15:0]          sel_half;

  assign word_idx = i_ALU_res[ADDR_W+1:2];
  assign lane     = i_ALU_res[1:0];

  always_comb begin
    misaligned = 1'b0;
    if (is_MemRead || is_MemWrite) begin
      if (is_half_type(is_load_store_type) && lane[0]) misaligned = 1'b1;
      if (is_word_type(is_load_store_type) && (lane != 2'b00)) misaligned = 1'b1;
    end
  end

  // Store data is replicated across lanes so the enables alone pick the bytes.
  always_comb begin
    byte_en = '0;
    wr_data = i_rt_reg;
    if (is_word_type(is_load_store_type)) begin
      byte_en = 4'b1111;
    end else if (is_half_type(is_load_store_type)) begin
      byte_en = lane[1] ? 4'b1100 : 4'b0011;
      wr_data = {2{i_rt_reg[15:0]}};
    end else begin
      byte_en = 4'b0001 << lane;
      wr_data = {4{i_rt_reg[7:0]}};
    end
    if (!(rst && i_enable && is_MemWrite && !misaligned)) byte_en = '0;
  end

  data_memory #(.ADDR_W(ADDR_W)) u_data_memory (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (i_enable),
    .addr     (word_idx),
    .byte_en  (byte_en),
    .wr_data  (wr_data),
    .rd_data  (rd_word),
    .dbg_addr (i_debug_addr),
    .dbg_data (o_debug_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_ALU_res          <= '0;
      o_pc_to_reg        <= '0;
      o_addr_reg_dst     <= '0;
      os_RegWrite        <= 1'b0;
      os_MemtoReg        <= 1'b0;
      os_select_addr_reg <= 1'b0;
      os_misaligned      <= 1'b0;
      lane_q             <= '0;
      type_q             <= '0;
    end else if (i_enable) begin
      o_ALU_res          <= i_ALU_res;
      o_pc_to_reg        <= i_pc_to_reg;
      o_addr_reg_dst     <= i_addr_reg_dst;
      os_RegWrite        <= is_RegWrite && !misaligned;
      os_MemtoReg        <= is_MemtoReg;
      os_select_addr_reg <= is_select_addr_reg;
      os_misaligned      <= misaligned;
      lane_q             <= lane;
      type_q             <= is_load_store_type;
    end
  end

  // Load extraction works purely on registered state, so outputs have no input path.
  always_comb begin
    sel_byte   = rd_word[{lane_q, 3'b000} +: 8];
    sel_half   = rd_word[{lane_q[1], 4'b0000} +: 16];
    o_mem_data = rd_word;
    case (type_q)
      LS_BYTE:   o_mem_data = {{24{sel_byte[7]}}, sel_byte};
      LS_HALF:   o_mem_data = {{16{sel_half[15]}}, sel_half};
      LS_BYTE_U: o_mem_data = {24'd0, sel_byte};
      LS_HALF_U: o_mem_data = {16'd0, sel_half};
      default:   o_mem_data = rd_word;
    endcase
    if (os_misaligned) o_mem_data = '0;
  end

endmodule

// File: tb/tb_stage_memory_access.sv
// Self-checking bench for stage_memory_access: reference memory model,
// expected-result queue, debug-port and reset checks.
module tb_stage_memory_access;
  import stage_memory_access_pkg::*;

  localparam int ADDR_W = 8;
  // Entry: chk_mem, mis, rw, mtr, sel, mem_data[32], alu[32], pc[32], dst[5]
  localparam int W = 106;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_enable;
  logic [31:0]       i_ALU_res, i_rt_reg, i_pc_to_reg;
  logic [4:0]        i_addr_reg_dst;
  logic              is_RegWrite, is_MemtoReg, is_MemWrite, is_MemRead, is_select_addr_reg;
  logic [2:0]        is_load_store_type;
  logic [ADDR_W-1:0] i_debug_addr;
  logic [31:0]       o_mem_data, o_ALU_res, o_pc_to_reg, o_debug_data;
  logic [4:0]        o_addr_reg_dst;
  logic              os_RegWrite, os_MemtoReg, os_select_addr_reg, os_misaligned;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_entry;
  logic [31:0]  mem_model [0:(1<<ADDR_W)-1];
  int tests_run = 0;
  int tests_failed = 0;

  stage_memory_access #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .i_enable(i_enable),
    .i_ALU_res(i_ALU_res), .i_rt_reg(i_rt_reg), .i_pc_to_reg(i_pc_to_reg),
    .i_addr_reg_dst(i_addr_reg_dst), .is_RegWrite(is_RegWrite), .is_MemtoReg(is_MemtoReg),
    .is_MemWrite(is_MemWrite), .is_MemRead(is_MemRead), .is_select_addr_reg(is_select_addr_reg),
    .is_load_store_type(is_load_store_type), .i_debug_addr(i_debug_addr),
    .o_mem_data(o_mem_data), .o_ALU_res(o_ALU_res), .o_pc_to_reg(o_pc_to_reg),
    .o_addr_reg_dst(o_addr_reg_dst), .os_RegWrite(os_RegWrite), .os_MemtoReg(os_MemtoReg),
    .os_select_addr_reg(os_select_addr_reg), .os_misaligned(os_misaligned),
    .o_debug_data(o_debug_data)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] t, input logic [31:0] w,
                                             input logic [1:0] ln);
    logic [7:0]  b;
    logic [15:0] h;
    case (ln)
      2'd0: b = w[7:0];
      2'd1: b = w[15:8];
      2'd2: b = w[23:16];
      default: b = w[31:24];
    endcase
    h = ln[1] ? w[31:16] : w[15:0];
    case (t)
      3'd0: return {{24{b[7]}}, b};
      3'd1: return {{16{h[15]}}, h};
      3'd3: return {24'd0, b};
      3'd4: return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // Driver: apply one instruction for one edge, push expectation, then compare.
  task automatic do_op(input string tag, input logic en, input logic [2:0] t,
                       input logic [31:0] addr, input logic [31:0] rt,
                       input logic rd, input logic wr, input logic rw);
    logic [ADDR_W-1:0] idx;
    logic [1:0]        ln;
    logic              mis;
    logic [31:0]       data;
    logic [W-1:0]      e, g;
    idx = addr[ADDR_W+1:2];
    ln  = addr[1:0];
    mis = (rd || wr) && ((((t == 3'd1) || (t == 3'd4)) && ln[0]) ||
                         (((t == 3'd2) || (t >= 3'd5)) && (ln != 2'd0)));
    i_enable = en; i_ALU_res = addr; i_rt_reg = rt; is_load_store_type = t;
    is_MemRead = rd; is_MemWrite = wr; is_RegWrite = rw; is_MemtoReg = rd;
    is_select_addr_reg = rt[0]; i_pc_to_reg = addr ^ 32'hA5A5_0000;
    i_addr_reg_dst = addr[6:2];
    if (en) begin
      data = mis ? 32'd0 : model_load(t, mem_model[idx], ln);
      e = {rd | mis, mis, rw & ~mis, rd, rt[0], data, addr, addr ^ 32'hA5A5_0000, addr[6:2]};
      if (wr && !mis) begin
        if ((t == 3'd1) || (t == 3'd4)) mem_model[idx][16*ln[1] +: 16] = rt[15:0];
        else if ((t == 3'd0) || (t == 3'd3)) mem_model[idx][8*ln +: 8] = rt[7:0];
        else mem_model[idx] = rt;
      end
      last_entry = e;
    end else begin
      e = last_entry;
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    g = exp_q.pop_front();
    check_val({tag, ".mis"}, {31'd0, os_misaligned}, {31'd0, g[104]});
    check_val({tag, ".rw"},  {31'd0, os_RegWrite}, {31'd0, g[103]});
    check_val({tag, ".mtr"}, {31'd0, os_MemtoReg}, {31'd0, g[102]});
    check_val({tag, ".sel"}, {31'd0, os_select_addr_reg}, {31'd0, g[101]});
    check_val({tag, ".alu"}, o_ALU_res, g[68:37]);
    check_val({tag, ".pc"},  o_pc_to_reg, g[36:5]);
    check_val({tag, ".dst"}, {27'd0, o_addr_reg_dst}, {27'd0, g[4:0]});
    if (g[105]) check_val({tag, ".data"}, o_mem_data, g[100:69]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, ".mem"}, o_mem_data, 32'd0);
    check_val({tag, ".alu"}, o_ALU_res, 32'd0);
    check_val({tag, ".pc"},  o_pc_to_reg, 32'd0);
    check_val({tag, ".dbg"}, o_debug_data, 32'd0);
    check_val({tag, ".flags"}, {28'd0, os_RegWrite, os_MemtoReg, os_select_addr_reg, os_misaligned}, 32'd0);
  endtask

  initial begin
    rst = 1'b0; i_enable = 1'b0; i_ALU_res = '0; i_rt_reg = '0; i_pc_to_reg = '0;
    i_addr_reg_dst = '0; is_RegWrite = 0; is_MemtoReg = 0; is_MemWrite = 0; is_MemRead = 0;
    is_select_addr_reg = 0; is_load_store_type = '0; i_debug_addr = '0; last_entry = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;

    // Word store/load
    do_op("sw_dead", 1, LS_WORD, 32'h10, 32'hDEADBEEF, 0, 1, 0);
    do_op("lw_dead", 1, LS_WORD, 32'h10, 32'h0, 1, 0, 1);

    // Byte lanes, signed and unsigned
    do_op("sw_80ff", 1, LS_WORD, 32'h10, 32'h80FF7F01, 0, 1, 0);
    for (int l = 0; l < 4; l++)
      do_op($sformatf("lb_l%0d", l), 1, LS_BYTE, 32'h10 + l, 32'h0, 1, 0, 1);
    do_op("lbu_l3", 1, LS_BYTE_U, 32'h13, 32'h0, 1, 0, 1);

    // Half stores/loads
    do_op("sw_20", 1, LS_WORD, 32'h20, 32'h11223344, 0, 1, 0);
    do_op("sh_22", 1, LS_HALF, 32'h22, 32'hAAAA8001, 0, 1, 0);
    do_op("lh_22", 1, LS_HALF, 32'h22, 32'h0, 1, 0, 1);
    do_op("lhu_22", 1, LS_HALF_U, 32'h22, 32'h0, 1, 0, 1);
    do_op("lw_20", 1, LS_WORD, 32'h20, 32'h0, 1, 0, 1);
    do_op("sb_21", 1, LS_BYTE, 32'h21, 32'h000000C5, 0, 1, 0);
    do_op("lbu_21", 1, LS_BYTE_U, 32'h21, 32'h0, 1, 0, 1);

    // Misaligned accesses
    do_op("lw_13", 1, LS_WORD, 32'h13, 32'h0, 1, 0, 1);
    do_op("lhu_23", 1, LS_HALF_U, 32'h23, 32'h0, 1, 0, 1);
    i_debug_addr = 8'd8;
    do_op("sh_21", 1, LS_HALF, 32'h21, 32'h0000FFFF, 0, 1, 1);
    do_op("idle_a", 1, LS_WORD, 32'h0, 32'h0, 0, 0, 0);
    check_val("dbg_w8", o_debug_data, mem_model[8]);
    do_op("mis_no_rw", 1, LS_WORD, 32'h2, 32'h0, 0, 0, 1);

    // Address wrap and illegal type acting as word
    do_op("sw_wrap", 1, LS_WORD, 32'h410, 32'hCAFEF00D, 0, 1, 0);
    do_op("lw_ill", 1, 3'd7, 32'h10, 32'h0, 1, 0, 1);
    do_op("lw_ill_mis", 1, 3'd6, 32'h12, 32'h0, 1, 0, 1);

    // Enable low holds state and blocks writes; debug port keeps running
    do_op("sw_30", 1, LS_WORD, 32'h30, 32'h0BADC0DE, 0, 1, 0);
    do_op("lw_10", 1, LS_WORD, 32'h10, 32'h0, 1, 0, 1);
    i_debug_addr = 8'd12;
    do_op("hold", 0, LS_WORD, 32'h30, 32'h12345678, 0, 1, 1);
    check_val("dbg_hold", o_debug_data, 32'h0BADC0DE);
    do_op("sw_land", 1, LS_WORD, 32'h30, 32'h12345678, 0, 1, 1);
    check_val("dbg_old", o_debug_data, 32'h0BADC0DE);
    do_op("idle_b", 1, LS_WORD, 32'h0, 32'h0, 0, 0, 0);
    check_val("dbg_new", o_debug_data, 32'h12345678);

    // Asynchronous reset with a store pending
    do_op("sw_40", 1, LS_WORD, 32'h40, 32'h01020304, 0, 1, 0);
    do_op("lw_40", 1, LS_WORD, 32'h40, 32'h0, 1, 0, 1);
    i_debug_addr = 8'd16;
    i_enable = 1'b1; i_ALU_res = 32'h40; i_rt_reg = 32'h55AA55AA; is_load_store_type = LS_WORD;
    is_MemWrite = 1'b1; is_MemRead = 1'b0; is_RegWrite = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    check_reset_outputs("rst_held");
    is_MemWrite = 1'b0; is_RegWrite = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    last_entry = '0;
    do_op("idle_c", 1, LS_WORD, 32'h0, 32'h0, 0, 0, 0);
    check_val("dbg_dropped", o_debug_data, 32'h01020304);
    do_op("lw_40_after", 1, LS_WORD, 32'h40, 32'h0, 1, 0, 1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
